// File: rtl/video_rd_pixel_sequencer_pkg.sv
// Shared definitions for the video-clock side of the DDR frame read path.
//   state_t        : line-fetch sequencer states
//   PIXEL_BITS     : meaningful bits of one pixel (RGB888)
//   PIX_SLOT_BITS  : bits reserved per pixel inside a FIFO word
package video_rd_pixel_sequencer_pkg;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  localparam int unsigned PIXEL_BITS    = 24;
  localparam int unsigned PIX_SLOT_BITS = 32;

endpackage

// File: rtl/video_sync_edge_detect.sv
// Registers the reference vsync/vde and derives single-cycle event pulses.
// Shared between the read and write sides of the frame buffer.
//   clk, rstn    : clock, asynchronous active-low reset
//   vsync, vde   : reference timing inputs
//   vsync_valid  : active level of vsync
//   vsync_d      : vsync delayed by one cycle
//   vde_d        : vde delayed by one cycle
//   vsync_edge   : vsync has just entered its active level (combinational)
//   vde_rise     : first cycle of a data-enable burst (combinational)
//   vde_fall     : first cycle after a data-enable burst (combinational)
module video_sync_edge_detect (
  input  logic clk,
  input  logic rstn,
  input  logic vsync,
  input  logic vsync_valid,
  input  logic vde,
  output logic vsync_d,
  output logic vde_d,
  output logic vsync_edge,
  output logic vde_rise,
  output logic vde_fall
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vsync_d <= 1'b0;
      vde_d   <= 1'b0;
    end else begin
      vsync_d <= vsync;
      vde_d   <= vde;
    end
  end

  assign vsync_edge = ({vsync_d, vsync} == {~vsync_valid, vsync_valid});
  assign vde_rise   = vde & ~vde_d;
  assign vde_fall   = ~vde & vde_d;

endmodule

// File: rtl/video_rd_pixel_sequencer.sv
// Video-clock end of the DDR frame read path. Pops 128-bit words from a
// first-word-fall-through line FIFO, unpacks them into 24-bit pixels and
// re-times them against the reference video timing, requesting one DDR line
// fetch per active line.
//   i_video1_clk, i_rstn        : pixel clock, asynchronous active-low reset
//   i_video_vde/hsync/vsync     : reference timing
//   i_video_vsync_valid         : active level of vsync
//   i_fifo_rdata, i_fifo_empty  : FWFT FIFO head word and empty flag
//   o_fifo_rd_en                : pop the head word
//   o_line_rq                   : one-cycle pulse requesting the next line
//   o_frame_start               : one-cycle pulse after the vsync active edge
//   o_underflow                 : sticky per-frame FIFO underflow flag
//   o_video_*                   : output video, one cycle behind the reference
module video_rd_pixel_sequencer
  import video_rd_pixel_sequencer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = 128,
  parameter int unsigned PIX_PER_WORD   = 4,
  parameter int unsigned IMG_LINES      = 1080,
  parameter int unsigned PREFETCH_LINES = 2
) (
  input  logic                  i_video1_clk,
  input  logic                  i_rstn,
  input  logic                  i_video_vde,
  input  logic                  i_video_hsync,
  input  logic                  i_video_vsync,
  input  logic                  i_video_vsync_valid,
  input  logic [WORD_WIDTH-1:0] i_fifo_rdata,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd_en,
  output logic                  o_line_rq,
  output logic                  o_frame_start,
  output logic                  o_underflow,
  output logic [23:0]           o_video_data,
  output logic                  o_video_vde,
  output logic                  o_video_hsync,
  output logic                  o_video_vsync
);

  localparam int unsigned IDX_W  = $clog2(PIX_PER_WORD);
  localparam int unsigned CNT_W  = $clog2(IMG_LINES + 1);
  localparam int unsigned SLOT_W = $clog2(WORD_WIDTH);

  state_t                state;
  logic [CNT_W-1:0]      req_cnt;
  logic [IDX_W-1:0]      pix_idx;
  logic [IDX_W-1:0]      idx_eff;
  logic [SLOT_W-1:0]     slot_base;
  logic [PIXEL_BITS-1:0] pixel;
  logic                  vsync_edge;
  logic                  vde_rise;
  logic                  vde_fall;
  logic                  active;
  logic                  last_slot;
  logic                  pop_pix;
  logic                  pop_tail;

  video_sync_edge_detect u_edge (
    .clk        (i_video1_clk),
    .rstn       (i_rstn),
    .vsync      (i_video_vsync),
    .vsync_valid(i_video_vsync_valid),
    .vde        (i_video_vde),
    .vsync_d    (o_video_vsync),
    .vde_d      (o_video_vde),
    .vsync_edge (vsync_edge),
    .vde_rise   (vde_rise),
    .vde_fall   (vde_fall)
  );

  // Pixels flow only once a frame has started.
  assign active = (state != S_WAIT);

  // The first pixel of a line always comes from slot 0, whatever pix_idx
  // was left at, so the clear on vde rise takes effect in the same cycle.
  assign idx_eff   = vde_rise ? '0 : pix_idx;
  assign slot_base = SLOT_W'(idx_eff) * SLOT_W'(PIX_SLOT_BITS);
  assign pixel     = i_fifo_rdata[slot_base +: PIXEL_BITS];
  assign last_slot = (idx_eff == IDX_W'(PIX_PER_WORD - 1));

  // The pop has to land in the same cycle the last slot is consumed: with a
  // FWFT FIFO a registered pop would re-read the old head word once more.
  assign pop_pix  = active & i_video_vde & ~i_fifo_empty & last_slot;
  // A line ending mid-word discards the rest of that word so the next line
  // starts word-aligned.
  assign pop_tail = active & vde_fall & (pix_idx != '0) & ~i_fifo_empty;
  assign o_fifo_rd_en = pop_pix | pop_tail;

  // Line-fetch sequencer with registered pulse outputs.
  always_ff @(posedge i_video1_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state         <= S_WAIT;
      req_cnt       <= '0;
      o_line_rq     <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_line_rq     <= 1'b0;
      o_frame_start <= 1'b0;
      // A frame start overrides everything, including a coincident line end.
      if (vsync_edge) begin
        state         <= S_PRIME;
        req_cnt       <= '0;
        o_frame_start <= 1'b1;
      end else begin
        case (state)
          S_WAIT: ;
          S_PRIME: begin
            o_line_rq <= 1'b1;
            req_cnt   <= req_cnt + 1'b1;
            if (req_cnt == CNT_W'(PREFETCH_LINES - 1)) state <= S_RUN;
          end
          S_RUN: begin
            if (vde_fall && (req_cnt < CNT_W'(IMG_LINES))) begin
              o_line_rq <= 1'b1;
              req_cnt   <= req_cnt + 1'b1;
            end
          end
          default: state <= S_WAIT;
        endcase
      end
    end
  end

  // Pixel unpacking, underflow tracking and output re-timing.
  always_ff @(posedge i_video1_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pix_idx       <= '0;
      o_underflow   <= 1'b0;
      o_video_data  <= '0;
      o_video_hsync <= 1'b0;
    end else begin
      if (vsync_edge)       pix_idx <= '0;
      else if (i_video_vde) pix_idx <= idx_eff + 1'b1;
      else if (vde_fall)    pix_idx <= '0;

      if (vsync_edge)                               o_underflow <= 1'b0;
      else if (active && i_video_vde && i_fifo_empty) o_underflow <= 1'b1;

      o_video_data  <= (active && i_video_vde && !i_fifo_empty) ? pixel : '0;
      o_video_hsync <= i_video_hsync;
    end
  end

endmodule

// File: tb/tb_video_rd_pixel_sequencer.sv
module tb_video_rd_pixel_sequencer;
  import video_rd_pixel_sequencer_pkg::*;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         vde = 1'b0, hsync = 1'b0, vsync = 1'b0, vsync_valid = 1'b1;
  logic [127:0] fifo_rdata;
  logic         fifo_empty;
  logic         fifo_rd_en, line_rq, frame_start, underflow;
  logic [23:0]  o_data;
  logic         o_vde, o_hsync, o_vsync;

  // FWFT FIFO model
  logic [127:0] mem [0:31];
  int unsigned  wr_ptr = 0;
  int unsigned  rd_ptr = 0;
  logic         force_empty = 1'b0;

  int unsigned  vectors = 0, miscompares = 0;
  int unsigned  n_rq = 0, n_fs = 0, n_pop = 0;
  int unsigned  snap_rq, snap_fs, snap_pop;
  logic [23:0]  exp_pix [0:13];

  always #5 clk = ~clk;

  assign fifo_empty = force_empty || (rd_ptr == wr_ptr);
  assign fifo_rdata = mem[rd_ptr % 32];

  always @(posedge clk) if (fifo_rd_en && !fifo_empty) rd_ptr <= rd_ptr + 1;

  always @(negedge clk) begin
    if (line_rq)     n_rq  <= n_rq + 1;
    if (frame_start) n_fs  <= n_fs + 1;
    if (fifo_rd_en)  n_pop <= n_pop + 1;
  end

  video_rd_pixel_sequencer #(
    .WORD_WIDTH    (128),
    .PIX_PER_WORD  (4),
    .IMG_LINES     (1080),
    .PREFETCH_LINES(2)
  ) dut (
    .i_video1_clk       (clk),
    .i_rstn             (rstn),
    .i_video_vde        (vde),
    .i_video_hsync      (hsync),
    .i_video_vsync      (vsync),
    .i_video_vsync_valid(vsync_valid),
    .i_fifo_rdata       (fifo_rdata),
    .i_fifo_empty       (fifo_empty),
    .o_fifo_rd_en       (fifo_rd_en),
    .o_line_rq          (line_rq),
    .o_frame_start      (frame_start),
    .o_underflow        (underflow),
    .o_video_data       (o_data),
    .o_video_vde        (o_vde),
    .o_video_hsync      (o_hsync),
    .o_video_vsync      (o_vsync)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [127:0] w);
    mem[wr_ptr % 32] = w;
    wr_ptr++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  32'(o_data), 0);
    check({tag, "_vde"},   32'(o_vde), 0);
    check({tag, "_hsync"}, 32'(o_hsync), 0);
    check({tag, "_vsync"}, 32'(o_vsync), 0);
    check({tag, "_rq"},    32'(line_rq), 0);
    check({tag, "_fs"},    32'(frame_start), 0);
    check({tag, "_uf"},    32'(underflow), 0);
    check({tag, "_rd_en"}, 32'(fifo_rd_en), 0);
  endtask

  // Drive one active line of npix pixels whose expected values start at
  // exp_pix[base]; the FIFO is assumed to hold enough words.
  task automatic drive_line(input int unsigned npix, input int unsigned base, input string tag);
    for (int unsigned k = 0; k < npix; k++) begin
      vde = 1'b1;
      hsync = (k == 0);
      #1;
      check({tag, "_rd_en"}, 32'(fifo_rd_en), 32'((k % 4) == 3));
      cyc();
      check({tag, "_pix"},   32'(o_data), 32'(exp_pix[base + k]));
      check({tag, "_vde"},   32'(o_vde), 1);
      check({tag, "_hsync"}, 32'(o_hsync), 32'(k == 0));
    end
    vde = 1'b0;
    hsync = 1'b0;
    #1;
    check({tag, "_tail_pop"}, 32'(fifo_rd_en), 32'((npix % 4) != 0));
    cyc();
    check({tag, "_blank_data"}, 32'(o_data), 0);
    check({tag, "_blank_vde"},  32'(o_vde), 0);
  endtask

  initial begin
    exp_pix[0]  = 24'h000001; exp_pix[1]  = 24'h000002;
    exp_pix[2]  = 24'h000003; exp_pix[3]  = 24'h000004;
    exp_pix[4]  = 24'h111111; exp_pix[5]  = 24'h222222;
    exp_pix[6]  = 24'h333333; exp_pix[7]  = 24'h444444;
    exp_pix[8]  = 24'h555555; exp_pix[9]  = 24'h666666;
    exp_pix[10] = 24'hAAAAAA; exp_pix[11] = 24'hBBBBBB;
    exp_pix[12] = 24'hCCCCCC; exp_pix[13] = 24'hDDDDDD;

    // Reset
    repeat (3) cyc();
    check_all_zero("reset");
    check("reset_state", 32'(dut.state), 32'(S_WAIT));
    rstn = 1'b1;
    repeat (2) cyc();

    // Frame start and prefetch
    vsync = 1'b1;
    cyc();
    check("fs_pulse", 32'(frame_start), 1);
    check("rq_before_prime", 32'(line_rq), 0);
    cyc();
    check("rq_prime0", 32'(line_rq), 1);
    check("fs_single", 32'(frame_start), 0);
    cyc();
    check("rq_prime1", 32'(line_rq), 1);
    check("state_run", 32'(dut.state), 32'(S_RUN));
    cyc();
    check("rq_prime_done", 32'(line_rq), 0);
    check("req_cnt_prime", 32'(dut.req_cnt), 2);
    check("vsync_out", 32'(o_vsync), 1);
    vsync = 1'b0;
    cyc();

    // 4-pixel burst from one word
    push(128'h00000004_00000003_00000002_00000001);
    snap_pop = n_pop;
    snap_rq  = n_rq;
    drive_line(4, 0, "burst4");
    check("burst4_line_rq", 32'(line_rq), 1);
    cyc();
    check("burst4_pops", n_pop - snap_pop, 1);
    check("burst4_rq_cnt", n_rq - snap_rq, 1);
    check("req_cnt_3", 32'(dut.req_cnt), 3);

    // 6-pixel line drops the rest of its second word; next line is aligned
    push({32'hBB444444, 32'hCC333333, 32'hDD222222, 32'hEE111111});
    push({32'h00888888, 32'h00777777, 32'h00666666, 32'h00555555});
    push({32'h00DDDDDD, 32'h00CCCCCC, 32'h00BBBBBB, 32'h99AAAAAA});
    snap_pop = n_pop;
    drive_line(6, 4, "line6");
    cyc();
    drive_line(4, 10, "line4");
    cyc();
    check("partial_pops", n_pop - snap_pop, 3);
    check("fifo_drained", 32'(fifo_empty), 1);
    check("no_underflow_yet", 32'(underflow), 0);

    // Underflow
    for (int i = 0; i < 3; i++) begin
      vde = 1'b1;
      #1;
      check("uf_rd_en", 32'(fifo_rd_en), 0);
      cyc();
      check("uf_data", 32'(o_data), 0);
      check("uf_vde", 32'(o_vde), 1);
      check("uf_flag", 32'(underflow), 1);
    end
    vde = 1'b0;
    #1;
    check("uf_tail_no_pop", 32'(fifo_rd_en), 0);
    repeat (3) cyc();
    check("uf_sticky", 32'(underflow), 1);
    vsync = 1'b1;
    cyc();
    check("uf_cleared", 32'(underflow), 0);
    check("uf_fs", 32'(frame_start), 1);
    repeat (3) cyc();
    vsync = 1'b0;
    cyc();

    // Full frame of 1080 lines
    snap_rq = n_rq;
    for (int i = 0; i < 1078; i++) begin
      vde = 1'b1; cyc();
      vde = 1'b0; cyc();
      cyc();
    end
    check("frame_rq_1078", n_rq - snap_rq, 1078);
    check("req_cnt_full", 32'(dut.req_cnt), 1080);
    for (int i = 0; i < 2; i++) begin
      vde = 1'b1; cyc();
      vde = 1'b0; cyc();
      check("no_rq_past_frame", 32'(line_rq), 0);
      cyc();
    end
    check("frame_rq_total", n_rq - snap_rq, 1078);

    // Vsync edge coincident with a vde falling edge
    snap_rq = n_rq;
    snap_fs = n_fs;
    vde = 1'b1;
    cyc();
    vde = 1'b0;
    vsync = 1'b1;
    cyc();
    check("coinc_fs", 32'(frame_start), 1);
    repeat (4) cyc();
    check("coinc_fs_cnt", n_fs - snap_fs, 1);
    check("coinc_rq_cnt", n_rq - snap_rq, 2);
    check("coinc_req_cnt", 32'(dut.req_cnt), 2);
    check("coinc_uf_clear", 32'(underflow), 0);
    vsync = 1'b0;
    cyc();

    // Reset in the middle of a line
    push({32'h0, 32'h0, 32'h0, 32'h00123456});
    vde = 1'b1;
    hsync = 1'b1;
    cyc();
    check("pre_rst_data", 32'(o_data), 32'h123456);
    check("pre_rst_vde", 32'(o_vde), 1);
    #1 rstn = 1'b0;
    #1;
    check_all_zero("mid_rst");
    cyc();
    rstn = 1'b1;
    #1;
    check("post_rst_rd_en", 32'(fifo_rd_en), 0);
    cyc();
    check("post_rst_vde", 32'(o_vde), 1);
    check("post_rst_blank", 32'(o_data), 0);
    check("post_rst_state", 32'(dut.state), 32'(S_WAIT));
    vde = 1'b0;
    hsync = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
